// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control unit of the five-stage RV64 core:
// address widths, the control FSM state encoding and the performance-counter
// saturation helper.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int ADDR_W = 64;   // PC / jump-address width
    localparam int REG_AW = 5;    // register-address width

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

    // Saturating increment for the performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == PERF_CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_det.sv
// -----------------------------------------------------------------------------
// load_use_det
// Purely combinational load-use hazard compare. Flags when the instruction in
// EX is a load whose (non-x0) destination is read by the instruction in decode.
// Kept separate so the forwarding unit can reuse the same compare.
//
// Ports:
//   i_rs1_addr  rs1 index read by decode (0 = no read)
//   i_rs2_addr  rs2 index read by decode (0 = no read)
//   i_mem_ren   instruction in EX is a load
//   i_rd_addr   destination of the instruction in EX
//   o_hazard    load-use hazard present this cycle
// -----------------------------------------------------------------------------
module load_use_det
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    input  logic              i_mem_ren,
    input  logic [REG_AW-1:0] i_rd_addr,
    output logic              o_hazard
);

    logic w_rd_nonzero;
    logic w_rd_match;

    // x0 is hard-wired zero, so a load into it never creates a dependency.
    assign w_rd_nonzero = (i_rd_addr != '0);
    assign w_rd_match   = (i_rd_addr == i_rs1_addr) || (i_rd_addr == i_rs2_addr);
    assign o_hazard     = i_mem_ren && w_rd_nonzero && w_rd_match;

endmodule : load_use_det

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the five-stage RV64 core. Issues one consistent
// hold / flush / redirect decision per cycle for the PC, IF/ID and ID/EX
// boundaries. Priority in RUN is jump > multi-cycle mul/div > load-use.
//
// Ports:
//   clk, rst                   core clock; synchronous active-low reset
//   id_rs1_addr_i/id_rs2_addr_i decode operand indices
//   ex_mem_ren_i, ex_rd_addr_i load in EX and its destination
//   ex_jump_en_i/ex_jump_addr_i taken branch/jump resolved in EX and target
//   ex_md_start_i, md_done_i   mul/div entered EX / result valid
//   hold_pc_o, hold_if_id_o, hold_id_ex_o   stage-register holds
//   flush_if_id_o, flush_id_ex_o            stage-register NOP loads
//   jump_en_o, jump_addr_o     PC redirect
//   busy_o                     FSM is not in RUN
//
// Optional feature (macro PIPE_CTRL_PERF_EN):
//   stall_cnt_o  cycles with hold_pc_o=1 (saturating)
//   flush_cnt_o  accepted jumps (saturating)
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              ex_mem_ren_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_jump_en_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              ex_md_start_i,
    input  logic              md_done_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              jump_en_o,
    output logic [ADDR_W-1:0] jump_addr_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o,
`endif
    output logic              busy_o
);

    state_e r_state;
    state_e w_next_state;

    logic w_load_use;
    logic w_hold_pc;
    logic w_hold_if_id;
    logic w_hold_id_ex;
    logic w_flush_if_id;
    logic w_flush_id_ex;
    logic w_jump_en;

    load_use_det u_load_use_det (
        .i_rs1_addr (id_rs1_addr_i),
        .i_rs2_addr (id_rs2_addr_i),
        .i_mem_ren  (ex_mem_ren_i),
        .i_rd_addr  (ex_rd_addr_i),
        .o_hazard   (w_load_use)
    );

    // NOTE: state uses non-blocking assignment so every reader sees the
    // pre-edge value; the reset is synchronous, so it only takes effect on a
    // rising clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first; without them any
    // path that skips an assignment would infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_hold_pc     = 1'b0;
        w_hold_if_id  = 1'b0;
        w_hold_id_ex  = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_jump_en     = 1'b0;

        case (r_state)
            RUN: begin
                if (ex_jump_en_i) begin
                    w_jump_en     = 1'b1;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_next_state  = REDIRECT;
                end else if (ex_md_start_i) begin
                    // A mul/div that finishes in its first EX cycle needs no stall.
                    if (!md_done_i) begin
                        w_hold_pc    = 1'b1;
                        w_hold_if_id = 1'b1;
                        w_hold_id_ex = 1'b1;
                        w_next_state = MD_WAIT;
                    end
                end else if (w_load_use) begin
                    // Exactly one bubble; the hazard is re-evaluated next cycle.
                    w_hold_pc     = 1'b1;
                    w_hold_if_id  = 1'b1;
                    w_flush_id_ex = 1'b1;
                end
            end

            MD_WAIT: begin
                // Jumps and load-use cannot be acted on while EX is frozen.
                if (md_done_i) begin
                    w_next_state = RUN;
                end else begin
                    w_hold_pc    = 1'b1;
                    w_hold_if_id = 1'b1;
                    w_hold_id_ex = 1'b1;
                end
            end

            REDIRECT: begin
                // Discard the wrong-path fetch still in flight; load-use is
                // meaningless against a flushed instruction.
                w_flush_if_id = 1'b1;
                if (ex_jump_en_i) begin
                    w_jump_en     = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_next_state  = REDIRECT;
                end else begin
                    w_next_state = RUN;
                end
            end

            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    // Outputs are forced low during reset; a flush on a register always
    // overrides a hold on the same register.
    assign hold_pc_o     = rst && w_hold_pc;
    assign hold_if_id_o  = rst && w_hold_if_id && !w_flush_if_id;
    assign hold_id_ex_o  = rst && w_hold_id_ex && !w_flush_id_ex;
    assign flush_if_id_o = rst && w_flush_if_id;
    assign flush_id_ex_o = rst && w_flush_id_ex;
    assign jump_en_o     = rst && w_jump_en;
    assign jump_addr_o   = jump_en_o ? ex_jump_addr_i : '0;
    assign busy_o        = rst && (r_state != RUN);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (hold_pc_o) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (jump_en_o) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: a directed vector table, hand-written
// multi-cycle sequences (long mul/div stall, redirect shape) and randomized
// stimulus against a behavioural model. Honours PIPE_CTRL_PERF_EN.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ren;
        logic [4:0]  rd;
        logic        jen;
        logic [63:0] jaddr;
        logic        mds;
        logic        mdd;
    } in_t;

    typedef struct packed {
        logic        hold_pc;
        logic        hold_if_id;
        logic        hold_id_ex;
        logic        flush_if_id;
        logic        flush_id_ex;
        logic        jump_en;
        logic [63:0] jump_addr;
        logic        busy;
    } outs_t;

    typedef struct {
        in_t   in;
        outs_t exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        ex_mem_ren_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_jump_en_i;
    logic [63:0] ex_jump_addr_i;
    logic        ex_md_start_i;
    logic        md_done_i;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        jump_en_o;
    logic [63:0] jump_addr_o;
    logic        busy_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;
`endif

    int    vectors     = 0;
    int    miscompares = 0;
    bit    m_md_wait   = 1'b0;   // model: waiting for mul/div completion
    bit    m_redirect  = 1'b0;   // model: one wrong-path fetch still to discard
    outs_t last;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .ex_mem_ren_i   (ex_mem_ren_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_jump_en_i   (ex_jump_en_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .ex_md_start_i  (ex_md_start_i),
        .md_done_i      (md_done_i),
        .hold_pc_o      (hold_pc_o),
        .hold_if_id_o   (hold_if_id_o),
        .hold_id_ex_o   (hold_id_ex_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
`endif
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                                  input logic ren, input logic [4:0] rd, input logic jen,
                                  input logic [63:0] ja, input logic mds, input logic mdd);
        in_t v;
        v.rst = r; v.rs1 = s1; v.rs2 = s2; v.ren = ren; v.rd = rd;
        v.jen = jen; v.jaddr = ja; v.mds = mds; v.mdd = mdd;
        return v;
    endfunction

    function automatic outs_t mk_out(input logic hpc, input logic hif, input logic hex,
                                     input logic fif, input logic fex, input logic jen,
                                     input logic [63:0] ja, input logic busy);
        outs_t o;
        o.hold_pc = hpc; o.hold_if_id = hif; o.hold_id_ex = hex;
        o.flush_if_id = fif; o.flush_id_ex = fex; o.jump_en = jen;
        o.jump_addr = ja; o.busy = busy;
        return o;
    endfunction

    // Behavioural model: pipeline mode is two flags, outputs follow the
    // priority rules directly.
    function automatic outs_t model(input in_t v, input bit md_wait, input bit redir,
                                    output bit nx_md, output bit nx_redir);
        outs_t o;
        bit    lu;
        o = '0;
        nx_md = 1'b0;
        nx_redir = 1'b0;
        lu = v.ren && (v.rd != 0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
        if (!v.rst) return o;
        o.busy = md_wait || redir;
        if (md_wait) begin
            if (!v.mdd) begin
                {o.hold_pc, o.hold_if_id, o.hold_id_ex} = 3'b111;
                nx_md = 1'b1;
            end
        end else begin
            if (redir) o.flush_if_id = 1'b1;
            if (v.jen) begin
                o.jump_en = 1'b1;
                o.jump_addr = v.jaddr;
                o.flush_if_id = 1'b1;
                o.flush_id_ex = 1'b1;
                nx_redir = 1'b1;
            end else if (!redir) begin
                if (v.mds) begin
                    if (!v.mdd) begin
                        {o.hold_pc, o.hold_if_id, o.hold_id_ex} = 3'b111;
                        nx_md = 1'b1;
                    end
                end else if (lu) begin
                    o.hold_pc = 1'b1;
                    o.hold_if_id = 1'b1;
                    o.flush_id_ex = 1'b1;
                end
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        rst            = v.rst;
        id_rs1_addr_i  = v.rs1;
        id_rs2_addr_i  = v.rs2;
        ex_mem_ren_i   = v.ren;
        ex_rd_addr_i   = v.rd;
        ex_jump_en_i   = v.jen;
        ex_jump_addr_i = v.jaddr;
        ex_md_start_i  = v.mds;
        md_done_i      = v.mdd;
    endtask

    // One clock cycle: apply inputs, compare mid-cycle, advance the model.
    task automatic cycle(input string name, input in_t v, input outs_t exp);
        outs_t m;
        bit    nmd;
        bit    nrd;
        drive(v);
        @(negedge clk);
        last.hold_pc     = hold_pc_o;
        last.hold_if_id  = hold_if_id_o;
        last.hold_id_ex  = hold_id_ex_o;
        last.flush_if_id = flush_if_id_o;
        last.flush_id_ex = flush_id_ex_o;
        last.jump_en     = jump_en_o;
        last.jump_addr   = jump_addr_o;
        last.busy        = busy_o;
        check(name, 128'(last), 128'(exp));
`ifdef PIPE_CTRL_PERF_EN
        check({name, ".stall_cnt"}, 128'(stall_cnt_o), 128'(m_stall_cnt));
        check({name, ".flush_cnt"}, 128'(flush_cnt_o), 128'(m_flush_cnt));
`endif
        m = model(v, m_md_wait, m_redirect, nmd, nrd);
        m_md_wait  = nmd;
        m_redirect = nrd;
`ifdef PIPE_CTRL_PERF_EN
        if (!v.rst) begin
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else begin
            if (m.hold_pc && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (m.jump_en && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] A = 64'h0000_0000_8000_0100;
    localparam logic [63:0] B = 64'h0000_0000_8000_0200;
    localparam logic [63:0] C = 64'h0000_0000_8000_1000;

    initial begin
        vec_t  tbl[$];
        in_t   idle;
        outs_t zero;
        int    n_hold;
        int    n_jump;
        int    n_fif;
        int    n_fex;

        idle = mk_in(1, 0, 0, 0, 0, 0, '0, 0, 0);
        zero = '0;
        drive(mk_in(0, 0, 0, 0, 0, 0, '0, 0, 0));
        @(posedge clk);
        #1;

        // ---------------- directed vector table (applied in sequence) ----
        tbl.push_back('{mk_in(0, 0, 5, 1, 5, 1, A, 0, 0), zero});                          // reset gates all
        tbl.push_back('{mk_in(1, 3, 5, 1, 5, 0, '0, 0, 0), mk_out(1, 1, 0, 0, 1, 0, '0, 0)}); // load-use rs2
        tbl.push_back('{mk_in(1, 3, 5, 0, 5, 0, '0, 0, 0), zero});                          // cleared
        tbl.push_back('{mk_in(1, 0, 7, 1, 0, 0, '0, 0, 0), zero});                          // load to x0
        tbl.push_back('{mk_in(1, 6, 0, 1, 6, 1, A, 0, 0), mk_out(0, 0, 0, 1, 1, 1, A, 0)}); // jump + load-use
        tbl.push_back('{mk_in(1, 6, 0, 1, 6, 0, '0, 0, 0), mk_out(0, 0, 0, 1, 0, 0, '0, 1)}); // REDIRECT
        tbl.push_back('{mk_in(1, 6, 0, 1, 7, 0, '0, 0, 0), zero});                          // no match
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 0, '0, 1, 1), zero});                          // 1-cycle md
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 0, '0, 1, 0), mk_out(1, 1, 1, 0, 0, 0, '0, 0)}); // md start
        tbl.push_back('{mk_in(1, 4, 4, 1, 4, 1, B, 0, 0), mk_out(1, 1, 1, 0, 0, 0, '0, 1)}); // jump ignored
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 0, '0, 0, 1), mk_out(0, 0, 0, 0, 0, 0, '0, 1)}); // md done
        tbl.push_back('{idle, zero});
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 1, A, 0, 0), mk_out(0, 0, 0, 1, 1, 1, A, 0)}); // jump
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 1, B, 0, 0), mk_out(0, 0, 0, 1, 1, 1, B, 1)}); // jump in REDIRECT
        tbl.push_back('{mk_in(1, 2, 0, 1, 2, 0, '0, 1, 0), mk_out(0, 0, 0, 1, 0, 0, '0, 1)}); // suppressed
        tbl.push_back('{idle, zero});
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 0, '0, 1, 0), mk_out(1, 1, 1, 0, 0, 0, '0, 0)}); // md start
        tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, '0, 0, 1), zero});                          // reset mid MD_WAIT
        tbl.push_back('{idle, zero});                                                       // back in RUN
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 1, C, 0, 0), mk_out(0, 0, 0, 1, 1, 1, C, 0)}); // jump
        tbl.push_back('{mk_in(0, 0, 0, 0, 0, 1, A, 0, 0), zero});                          // reset mid REDIRECT
        tbl.push_back('{idle, zero});
        tbl.push_back('{mk_in(1, 9, 3, 1, 9, 0, '0, 0, 0), mk_out(1, 1, 0, 0, 1, 0, '0, 0)}); // load-use rs1
        tbl.push_back('{idle, zero});
        tbl.push_back('{mk_in(1, 9, 0, 1, 9, 0, '0, 1, 0), mk_out(1, 1, 1, 0, 0, 0, '0, 0)}); // md beats load-use
        tbl.push_back('{mk_in(1, 0, 0, 0, 0, 0, '0, 0, 1), mk_out(0, 0, 0, 0, 0, 0, '0, 1)});
        tbl.push_back('{idle, zero});

        foreach (tbl[i]) cycle($sformatf("vec[%0d]", i), tbl[i].in, tbl[i].exp);

        // ---------------- 33-cycle mul/div stall -------------------------
        cycle("md33_start", mk_in(1, 0, 0, 0, 0, 0, '0, 1, 0), mk_out(1, 1, 1, 0, 0, 0, '0, 0));
        n_hold = int'(last.hold_pc);
        for (int i = 1; i < 33; i++) begin
            cycle($sformatf("md33_wait[%0d]", i), idle, mk_out(1, 1, 1, 0, 0, 0, '0, 1));
            n_hold += int'(last.hold_pc);
        end
        cycle("md33_done", mk_in(1, 0, 0, 0, 0, 0, '0, 0, 1), mk_out(0, 0, 0, 0, 0, 0, '0, 1));
        n_hold += int'(last.hold_pc);
        check("md33_stall_len", 128'(n_hold), 128'(33));
        cycle("md33_after", idle, zero);

        // ---------------- redirect shape ---------------------------------
        n_jump = 0; n_fif = 0; n_fex = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) cycle("jmp_resolve", mk_in(1, 0, 0, 0, 0, 1, A, 0, 0), mk_out(0, 0, 0, 1, 1, 1, A, 0));
            else if (i == 1) cycle("jmp_redirect", idle, mk_out(0, 0, 0, 1, 0, 0, '0, 1));
            else cycle($sformatf("jmp_after[%0d]", i), idle, zero);
            n_jump += int'(last.jump_en);
            n_fif  += int'(last.flush_if_id);
            n_fex  += int'(last.flush_id_ex);
        end
        check("jmp_en_cycles", 128'(n_jump), 128'(1));
        check("jmp_flush_if_id_cycles", 128'(n_fif), 128'(2));
        check("jmp_flush_id_ex_cycles", 128'(n_fex), 128'(1));

        // ---------------- randomized against the model -------------------
        for (int i = 0; i < 1500; i++) begin
            in_t   v;
            outs_t e;
            bit    d0;
            bit    d1;
            v.rst   = ($urandom_range(0, 99) >= 3);
            v.rs1   = 5'($urandom_range(0, 7));
            v.rs2   = 5'($urandom_range(0, 7));
            v.ren   = ($urandom_range(0, 99) < 40);
            v.rd    = 5'($urandom_range(0, 7));
            v.jen   = ($urandom_range(0, 99) < 15);
            v.jaddr = {32'($urandom), 32'($urandom)};
            v.mds   = ($urandom_range(0, 99) < 10);
            v.mdd   = ($urandom_range(0, 99) < 30);
            e = model(v, m_md_wait, m_redirect, d0, d1);
            cycle($sformatf("rand[%0d]", i), v, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RV64 core. It sits beside the decode stage and issues the stall, bubble and redirect controls for the fetch, decode and execute boundaries. Inputs come from decode operand addresses, the execute-stage load, jump and multi-cycle mul/div signals, and the divider's completion strobe. Priority and sequencing are fixed by one small state machine, so every stage-boundary register sees exactly one consistent hold/flush decision per cycle.

## Interface
- ADDR_W, 64, PC / jump-address width
- REG_AW, 5, register-address width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- id_rs1_addr_i  in  REG_AW  rs1 index read by decode (0 = no read)
- id_rs2_addr_i  in  REG_AW  rs2 index read by decode (0 = no read)
- ex_mem_ren_i  in  1  instruction in EX is a load
- ex_rd_addr_i  in  REG_AW  destination of instruction in EX
- ex_jump_en_i  in  1  EX resolved a taken branch/jump
- ex_jump_addr_i  in  ADDR_W  redirect target
- ex_md_start_i  in  1  multi-cycle mul/div entered EX this cycle
- md_done_i  in  1  mul/div result valid this cycle
- hold_pc_o  out  1  PC keeps value
- hold_if_id_o  out  1  IF/ID register keeps value
- hold_id_ex_o  out  1  ID/EX register keeps value
- flush_if_id_o  out  1  IF/ID loads a NOP
- flush_id_ex_o  out  1  ID/EX loads a NOP (bubble)
- jump_en_o  out  1  PC loads jump_addr_o
- jump_addr_o  out  ADDR_W  ex_jump_addr_i when jump_en_o, else 0
- busy_o  out  1  state != RUN

## Operation
- States: RUN, MD_WAIT, REDIRECT. Reset state RUN.
- Load-use hazard: ex_mem_ren_i & ex_rd_addr_i!=0 & (ex_rd_addr_i==id_rs1_addr_i | ex_rd_addr_i==id_rs2_addr_i).
- RUN, priority jump > md > load-use:
  - ex_jump_en_i: jump_en_o=1, flush_if_id_o=1, flush_id_ex_o=1; next REDIRECT.
  - ex_md_start_i & !md_done_i: hold_pc_o, hold_if_id_o, hold_id_ex_o = 1; next MD_WAIT.
  - ex_md_start_i & md_done_i: single-cycle op, no action, stay RUN.
  - load-use: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1; stay RUN (exactly one bubble, re-evaluated next cycle).
- MD_WAIT: all three holds = 1 until md_done_i; on md_done_i, holds drop in the same cycle and the next state is RUN. ex_jump_en_i and load-use are ignored.
- REDIRECT: flush_if_id_o=1, discarding the wrong-path fetch in flight. Load-use is suppressed. Next state is RUN. If ex_jump_en_i is asserted, it is handled as in RUN and the state stays REDIRECT.
- A hold and a flush never assert on the same register in the same cycle. When both apply, flush wins.
- All outputs are combinational functions of the state and the inputs, and are forced to 0 while rst=0.

## Timing
- Zero-cycle decision latency: controls act on the edge that ends the cycle in which the condition is seen.
- Redirect costs 2 bubbles: the cycle in which the jump resolves plus one REDIRECT cycle.
- A load-use hazard costs exactly 1 bubble.
- A mul/div that completes in cycle N releases the pipeline in cycle N, so the stall length equals the divider latency minus 1.
- Reset mid-MD_WAIT or mid-REDIRECT: the state goes to RUN on the next edge, and the outputs are 0 during reset.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments every cycle in which hold_pc_o=1.
  - flush_cnt_o increments once per accepted jump.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- PIPE_CTRL_PERF_EN undefined: the ports and counters are absent, with no functional difference.

## Structure
- The shared defines package holds the state encoding constants (RUN=2'd0, MD_WAIT=2'd1, REDIRECT=2'd2), REG_AW and ADDR_W.
- One sub-module, load_use_det: purely combinational hazard compare, reusable by the future forwarding unit.

## Test plan
- Load x5 in EX, decode reads rs2=x5 -> one cycle with hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1, then clear.
- Load with rd=x0, decode reads x0 -> no stall.
- ex_md_start_i with md_done_i arriving 33 cycles later -> holds high for 33 cycles, busy_o=1, release in the md_done_i cycle.
- ex_jump_en_i, target 64'h8000_0100 -> jump_en_o=1 and jump_addr_o=64'h8000_0100 for 1 cycle, flush_if_id_o high for 2 cycles, flush_id_ex_o high for 1 cycle.
- Jump and load-use in the same cycle -> only the redirect is seen, no hold asserted.
- rst=0 during MD_WAIT -> all outputs 0, state RUN after release; with PIPE_CTRL_PERF_EN, counters read 0.
